// File: rtl/pe_row_sched.sv
// pe_row_sched: row-stationary scheduler for a single 1-D convolution PE.
// For every output row r it runs FIL_S PE passes (k = 0..FIL_S-1). Each pass
// feeds ifmap row r+k and filter row k to the PE and chains the partial sum
// through the external accumulator row. The finished row is then offered
// downstream with a valid/ready handshake. A PE that stays silent for TIMEOUT
// WAIT cycles abandons the tile and raises a sticky error flag.
module pe_row_sched #(
    parameter int FIL_S   = 3,
    parameter int DO_H    = 5,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pe_done,
    input  logic              ofmap_ready,
    output logic              pe_en,
    output logic [ADDR_W-1:0] ifmap_addr,
    output logic [ADDR_W-1:0] filt_addr,
    output logic              psum_zero,
    output logic              psum_we,
    output logic              ofmap_valid,
    output logic [ADDR_W-1:0] ofmap_row,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The WAIT counter only has to reach TIMEOUT-1, so TIMEOUT+1 codes suffice.
    localparam int T_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(FIL_S - 1);
    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(DO_H - 1);
    localparam logic [T_W-1:0]    T_LAST = T_W'(TIMEOUT - 1);
    localparam logic [T_W-1:0]    T_SAT  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] r_q;
    logic [ADDR_W-1:0] r_d;
    logic [ADDR_W-1:0] k_q;
    logic [ADDR_W-1:0] k_d;
    logic [T_W-1:0]    t_q;
    logic [T_W-1:0]    t_d;
    logic              err_q;
    logic              err_d;
    logic              done_q;
    logic              done_d;

    // Sequencing: walk k within a row, r across the tile, and watch the PE timeout.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        t_d     = t_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = '0;
                    k_d     = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                t_d     = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A done pulse in the last allowed cycle beats the timeout.
                if (pe_done) begin
                    if (k_q < K_LAST) begin
                        k_d     = k_q + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_OUT;
                    end
                end else if (t_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (t_q != T_SAT) begin
                    t_d = t_q + 1'b1;
                end
            end

            S_OUT: begin
                if (ofmap_ready) begin
                    if (r_q < R_LAST) begin
                        r_d     = r_q + 1'b1;
                        k_d     = '0;
                        state_d = S_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; a low rst abandons any tile in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            k_q     <= '0;
            t_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            t_q     <= t_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Output decode: addresses come straight from r/k, strobes from the state.
    always_comb begin
        pe_en       = (state_q == S_ISSUE);
        psum_we     = (state_q == S_WAIT) && pe_done;
        ofmap_valid = (state_q == S_OUT);
        busy        = (state_q != S_IDLE);
        done        = done_q;
        err         = err_q;
        ifmap_addr  = r_q + k_q;
        filt_addr   = k_q;
        psum_zero   = (k_q == '0);
        ofmap_row   = r_q;
    end

endmodule

// File: tb/tb_pe_row_sched.sv
// tb_pe_row_sched: directed bench for pe_row_sched. A pass-level reference
// model (tile position held as a single pass index) is checked against the
// DUT every cycle, and hand-computed expectations pin the sequences.
module tb_pe_row_sched;

    localparam int FIL_S   = 3;
    localparam int DO_H    = 5;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 15;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WAIT  = 2;
    localparam int P_OUT   = 3;

    logic clk            = 1'b0;
    logic rst            = 1'b0;
    logic start          = 1'b0;
    logic ofmap_ready    = 1'b1;
    logic pe_done_auto   = 1'b0;
    logic pe_done_manual = 1'b0;
    logic pe_done;

    logic              pe_en;
    logic [ADDR_W-1:0] ifmap_addr;
    logic [ADDR_W-1:0] filt_addr;
    logic              psum_zero;
    logic              psum_we;
    logic              ofmap_valid;
    logic [ADDR_W-1:0] ofmap_row;
    logic              busy;
    logic              done;
    logic              err;

    assign pe_done = pe_done_auto | pe_done_manual;

    pe_row_sched #(
        .FIL_S  (FIL_S),
        .DO_H   (DO_H),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pe_done    (pe_done),
        .ofmap_ready(ofmap_ready),
        .pe_en      (pe_en),
        .ifmap_addr (ifmap_addr),
        .filt_addr  (filt_addr),
        .psum_zero  (psum_zero),
        .psum_we    (psum_we),
        .ofmap_valid(ofmap_valid),
        .ofmap_row  (ofmap_row),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Cycle counter shared by the recorder and the directed checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // PE stand-in: answers each pe_en with pe_done pe_delay cycles later.
    int pe_cnt     = 0;
    int pe_delay   = 7;
    bit pe_respond = 1'b1;
    always @(posedge clk) begin
        #1;
        pe_done_auto = 1'b0;
        if (pe_cnt > 0) begin
            pe_cnt--;
            if (pe_cnt == 0) pe_done_auto = 1'b1;
        end
        if (pe_en === 1'b1 && pe_respond) pe_cnt = pe_delay;
    end

    // Reference model: the tile position is a single pass index p, r = p/FIL_S, k = p%FIL_S.
    int m_phase = P_IDLE;
    int m_pass  = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;
    bit m_done  = 1'b0;
    bit check_en = 1'b0;
    int e_r;
    int e_k;

    // Per-cycle compare against the model, then advance the model on this cycle's inputs.
    always @(negedge clk) begin
        e_r = m_pass / FIL_S;
        e_k = m_pass % FIL_S;
        if (check_en) begin
            checkOutput("pe_en",       32'(pe_en),       32'(m_phase == P_ISSUE));
            checkOutput("psum_we",     32'(psum_we),     32'(m_phase == P_WAIT && pe_done));
            checkOutput("ofmap_valid", 32'(ofmap_valid), 32'(m_phase == P_OUT));
            checkOutput("busy",        32'(busy),        32'(m_phase != P_IDLE));
            checkOutput("done",        32'(done),        32'(m_done));
            checkOutput("err",         32'(err),         32'(m_err));
            checkOutput("ifmap_addr",  32'(ifmap_addr),  32'(e_r + e_k));
            checkOutput("filt_addr",   32'(filt_addr),   32'(e_k));
            checkOutput("ofmap_row",   32'(ofmap_row),   32'(e_r));
            checkOutput("psum_zero",   32'(psum_zero),   32'(e_k == 0));
        end
        if (!rst) begin
            m_phase  = P_IDLE;
            m_pass   = 0;
            m_wait   = 0;
            m_err    = 1'b0;
            m_done   = 1'b0;
            check_en = 1'b1;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                P_IDLE: if (start) begin
                    m_pass  = 0;
                    m_err   = 1'b0;
                    m_phase = P_ISSUE;
                end
                P_ISSUE: begin
                    m_wait  = 0;
                    m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (pe_done) begin
                        if (m_pass % FIL_S == FIL_S - 1) m_phase = P_OUT;
                        else begin
                            m_pass++;
                            m_phase = P_ISSUE;
                        end
                    end else if (m_wait == TIMEOUT - 1) begin
                        m_err   = 1'b1;
                        m_phase = P_IDLE;
                    end else begin
                        m_wait++;
                    end
                end
                default: if (ofmap_ready) begin
                    if (m_pass / FIL_S == DO_H - 1) begin
                        m_done  = 1'b1;
                        m_phase = P_IDLE;
                    end else begin
                        m_pass++;
                        m_phase = P_ISSUE;
                    end
                end
            endcase
        end
    end

    int pe_if_q[$];
    int pe_f_q[$];
    int pe_z_q[$];
    int pe_cyc_q[$];
    int row_q[$];
    int done_cyc_q[$];
    int we_cyc_q[$];

    // Event recorder feeding the hand-computed sequence checks.
    always @(negedge clk) begin
        if (check_en) begin
            if (pe_en === 1'b1) begin
                pe_if_q.push_back(int'(ifmap_addr));
                pe_f_q.push_back(int'(filt_addr));
                pe_z_q.push_back(int'(psum_zero));
                pe_cyc_q.push_back(cyc);
            end
            if (ofmap_valid === 1'b1 && ofmap_ready === 1'b1) row_q.push_back(int'(ofmap_row));
            if (done === 1'b1) done_cyc_q.push_back(cyc);
            if (psum_we === 1'b1) we_cyc_q.push_back(cyc);
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        pe_if_q.delete();
        pe_f_q.delete();
        pe_z_q.delete();
        pe_cyc_q.delete();
        row_q.delete();
        done_cyc_q.delete();
        we_cyc_q.delete();
    endtask

    // One-cycle start pulse.
    task automatic applyStimulus();
        start = 1'b1;
        wait_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cyc_q.size() == 0 && n < budget) begin
            wait_cycle();
            n++;
        end
        checkOutput(name, 32'(done_cyc_q.size()), 32'd1);
    endtask

    function automatic int qval(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    int exp_if[6] = '{0, 1, 2, 1, 2, 3};
    int exp_f[6]  = '{0, 1, 2, 0, 1, 2};

    initial begin
        int n;
        int err_cyc;

        // Reset
        rst = 1'b0;
        repeat (3) wait_cycle();
        rst = 1'b1;
        wait_cycle();
        checkOutput("rst_busy",  32'(busy),       32'd0);
        checkOutput("rst_pe_en", 32'(pe_en),      32'd0);
        checkOutput("rst_ifmap", 32'(ifmap_addr), 32'd0);
        checkOutput("rst_filt",  32'(filt_addr),  32'd0);
        checkOutput("rst_err",   32'(err),        32'd0);

        // Nominal tile, D=7, ready held high
        clear_logs();
        applyStimulus();
        wait_done(400, "nom_done_seen");
        checkOutput("nom_pe_count", 32'(pe_if_q.size()), 32'd15);
        for (int i = 0; i < 6; i++) begin
            checkOutput("nom_ifmap_seq", 32'(qval(pe_if_q, i)), 32'(exp_if[i]));
            checkOutput("nom_filt_seq",  32'(qval(pe_f_q, i)),  32'(exp_f[i]));
        end
        checkOutput("nom_last_ifmap", 32'(qval(pe_if_q, 14)), 32'd6);
        checkOutput("nom_last_filt",  32'(qval(pe_f_q, 14)),  32'd2);
        for (int i = 0; i < 15; i++)
            checkOutput("nom_psum_zero", 32'(qval(pe_z_q, i)), 32'(i % 3 == 0));
        checkOutput("nom_row_count", 32'(row_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            checkOutput("nom_row_idx", 32'(qval(row_q, i)), 32'(i));
        checkOutput("nom_tile_len", 32'(qval(done_cyc_q, 0) - qval(pe_cyc_q, 0)), 32'd125);

        // Backpressure on row 2, then start in the done cycle
        clear_logs();
        applyStimulus();
        n = 0;
        while (row_q.size() < 2 && n < 200) begin wait_cycle(); n++; end
        ofmap_ready = 1'b0;
        n = 0;
        while (!(ofmap_valid === 1'b1 && ofmap_row == 3'd2) && n < 200) begin wait_cycle(); n++; end
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid",    32'(ofmap_valid), 32'd1);
            checkOutput("bp_row",      32'(ofmap_row),   32'd2);
            checkOutput("bp_no_pe_en", 32'(pe_en),       32'd0);
            wait_cycle();
        end
        ofmap_ready = 1'b1;
        wait_cycle();
        checkOutput("bp_r3_pe_en", 32'(pe_en),      32'd1);
        checkOutput("bp_r3_filt",  32'(filt_addr),  32'd0);
        checkOutput("bp_r3_ifmap", 32'(ifmap_addr), 32'd3);
        n = 0;
        while (done !== 1'b1 && n < 300) begin wait_cycle(); n++; end
        checkOutput("bp_done",      32'(done),         32'd1);
        checkOutput("bp_done_busy", 32'(busy),         32'd0);
        checkOutput("bp_row_count", 32'(row_q.size()), 32'd5);
        start = 1'b1;
        ofmap_ready = 1'b0;
        wait_cycle();
        start = 1'b0;
        checkOutput("restart_pe_en", 32'(pe_en), 32'd1);
        checkOutput("restart_busy",  32'(busy),  32'd1);

        // Spurious start in WAIT, spurious pe_done in OUT
        clear_logs();
        wait_cycle();
        wait_cycle();
        start = 1'b1;
        wait_cycle();
        start = 1'b0;
        n = 0;
        while (ofmap_valid !== 1'b1 && n < 100) begin wait_cycle(); n++; end
        checkOutput("sp_out_row",  32'(ofmap_row), 32'd0);
        checkOutput("sp_filt_pre", 32'(filt_addr), 32'd2);
        pe_done_manual = 1'b1;
        #1;
        checkOutput("sp_no_psum_we", 32'(psum_we), 32'd0);
        wait_cycle();
        pe_done_manual = 1'b0;
        checkOutput("sp_filt_post",  32'(filt_addr),   32'd2);
        checkOutput("sp_still_out",  32'(ofmap_valid), 32'd1);
        ofmap_ready = 1'b1;
        wait_done(400, "sp_done_seen");
        checkOutput("sp_pe_count", 32'(pe_if_q.size()), 32'd15);

        // Timeout: PE never answers
        wait_cycle();
        pe_respond = 1'b0;
        clear_logs();
        applyStimulus();
        n = 0;
        while (err !== 1'b1 && n < 60) begin wait_cycle(); n++; end
        err_cyc = cyc;
        checkOutput("to_err",       32'(err),  32'd1);
        checkOutput("to_err_cycle", 32'(err_cyc - qval(pe_cyc_q, 0)), 32'd16);
        checkOutput("to_busy",      32'(busy), 32'd0);
        repeat (3) wait_cycle();
        checkOutput("to_err_sticky", 32'(err), 32'd1);
        checkOutput("to_no_done",    32'(done_cyc_q.size()), 32'd0);
        pe_respond = 1'b1;
        applyStimulus();
        checkOutput("to_err_cleared", 32'(err),   32'd0);
        checkOutput("to_new_pe_en",   32'(pe_en), 32'd1);

        // Reset mid-tile at row 1, k 1, WAIT
        n = 0;
        while (!(pe_en === 1'b1 && ifmap_addr == 3'd2 && filt_addr == 3'd1) && n < 100) begin wait_cycle(); n++; end
        wait_cycle();
        checkOutput("mr_in_wait_row", 32'(ofmap_row), 32'd1);
        rst = 1'b0;
        pe_cnt = 0;
        wait_cycle();
        rst = 1'b1;
        pe_cnt = 0;
        checkOutput("mr_pe_en",   32'(pe_en),       32'd0);
        checkOutput("mr_psum_we", 32'(psum_we),     32'd0);
        checkOutput("mr_valid",   32'(ofmap_valid), 32'd0);
        checkOutput("mr_busy",    32'(busy),        32'd0);
        checkOutput("mr_done",    32'(done),        32'd0);
        checkOutput("mr_err",     32'(err),         32'd0);
        checkOutput("mr_ifmap",   32'(ifmap_addr),  32'd0);
        checkOutput("mr_filt",    32'(filt_addr),   32'd0);
        checkOutput("mr_row",     32'(ofmap_row),   32'd0);
        clear_logs();
        applyStimulus();
        checkOutput("mr_restart_pe_en", 32'(pe_en),      32'd1);
        checkOutput("mr_restart_ifmap", 32'(ifmap_addr), 32'd0);
        checkOutput("mr_restart_filt",  32'(filt_addr),  32'd0);
        wait_done(400, "mr_done_seen");

        // pe_done lands in the last allowed WAIT cycle
        wait_cycle();
        pe_delay = 15;
        clear_logs();
        applyStimulus();
        n = 0;
        while (we_cyc_q.size() == 0 && n < 40) begin wait_cycle(); n++; end
        checkOutput("sim_we_latency", 32'(qval(we_cyc_q, 0) - qval(pe_cyc_q, 0)), 32'd15);
        checkOutput("sim_err",        32'(err), 32'd0);
        wait_done(700, "sim_done_seen");
        checkOutput("sim_pe_count",  32'(pe_if_q.size()), 32'd15);
        checkOutput("sim_tile_len",  32'(qval(done_cyc_q, 0) - qval(pe_cyc_q, 0)), 32'd245);
        checkOutput("sim_err_final", 32'(err), 32'd0);

        wait_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
